// File: rtl/stage_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// stage_pkg
// Shared types and helpers for the display stage sequencer.
//   stage_t      : stage encoding, also exported on o_stage.
//   count_width  : width of a frame counter that must hold values up to the
//                  largest of the three frame limits.
// -----------------------------------------------------------------------------
package stage_pkg;

  typedef enum logic [2:0] {
    ST_MENU = 3'd0,
    ST_WAIT = 3'd1,
    ST_FADE = 3'd2,
    ST_PLAY = 3'd3,
    ST_OVER = 3'd4
  } stage_t;

  // Bits needed to count up to the largest of three frame limits, inclusive.
  function automatic int count_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/stage_sequencer_frame_tick_counter.sv
// -----------------------------------------------------------------------------
// frame_tick_counter
// Counts frame pulses and flags the pulse that lands on the last frame of a
// window of 'terminal' frames.
//   i_clk_pix : pixel clock
//   i_rst     : asynchronous reset, active-high
//   clear     : synchronous clear, wins over counting
//   i_frame   : one-cycle frame pulse
//   terminal  : window length in frames (>= 1)
//   count     : frames counted since the last clear
//   expire    : high in the cycle where i_frame arrives with count = terminal-1
//               (combinational, consumed only by registered logic)
// -----------------------------------------------------------------------------
module frame_tick_counter
  import stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk_pix,
  input  logic         i_rst,
  input  logic         clear,
  input  logic         i_frame,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         expire
);

  logic [W-1:0] count_reg;

  always_ff @(posedge i_clk_pix or posedge i_rst) begin
    if (i_rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (i_frame) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count  = count_reg;
  assign expire = i_frame && (count_reg == (terminal - W'(1)));

endmodule

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
// Frame-synchronous controller for the game display stages:
// MENU -> WAIT (start handshake) -> FADE (menu fade-out) -> PLAY -> OVER -> MENU,
// with WAIT falling back to MENU if the main game never reports ready.
// Layer ownership only moves on a frame pulse so the screen never tears.
//   i_clk_pix     : pixel clock
//   i_rst         : asynchronous reset, active-high
//   i_frame       : one-cycle pulse at start of each frame
//   i_start_req   : menu request to start (pulse or level), honoured in MENU only
//   i_main_ready  : main game loaded (level)
//   i_main_done   : main game over (pulse), honoured in PLAY only
//   o_main_start  : start handshake, high for all of WAIT
//   o_menu_active : menu layer owns the pixel mux
//   o_main_active : main layer owns the pixel mux
//   o_stage       : current stage_t encoding
//   o_fade_level  : frames elapsed in FADE, 0 elsewhere
//   o_timeout     : one-cycle pulse when the ready wait is abandoned
// -----------------------------------------------------------------------------
module stage_sequencer
  import stage_pkg::*;
#(
  parameter int FADE_FRAMES   = 16,
  parameter int HOLD_FRAMES   = 120,
  parameter int READY_TIMEOUT = 255
) (
  input  logic                               i_clk_pix,
  input  logic                               i_rst,
  input  logic                               i_frame,
  input  logic                               i_start_req,
  input  logic                               i_main_ready,
  input  logic                               i_main_done,
  output logic                               o_main_start,
  output logic                               o_menu_active,
  output logic                               o_main_active,
  output logic [2:0]                         o_stage,
  output logic [$clog2(FADE_FRAMES+1)-1:0]   o_fade_level,
  output logic                               o_timeout
);

  localparam int CW = count_width(FADE_FRAMES, HOLD_FRAMES, READY_TIMEOUT);
  localparam int FW = $clog2(FADE_FRAMES + 1);

  stage_t        state_reg;
  logic          menu_active_reg;
  logic          main_active_reg;
  logic          main_start_reg;
  logic          timeout_reg;
  logic          done_pending_reg;

  logic          cnt_clear;
  logic [CW-1:0] cnt_terminal;
  logic [CW-1:0] cnt_value;
  logic          cnt_expire;

  // One counter serves WAIT, FADE and OVER. It is held at zero in MENU and
  // PLAY and cleared on the edge that leaves a counting stage, so every
  // counting stage starts from zero and the count can never wrap.
  always_comb begin
    cnt_terminal = CW'(READY_TIMEOUT);
    cnt_clear    = 1'b1;
    case (state_reg)
      ST_WAIT: begin
        cnt_terminal = CW'(READY_TIMEOUT);
        cnt_clear    = i_main_ready || cnt_expire;
      end
      ST_FADE: begin
        cnt_terminal = CW'(FADE_FRAMES);
        cnt_clear    = cnt_expire;
      end
      ST_OVER: begin
        cnt_terminal = CW'(HOLD_FRAMES);
        cnt_clear    = cnt_expire;
      end
      default: begin
        cnt_terminal = CW'(READY_TIMEOUT);
        cnt_clear    = 1'b1;
      end
    endcase
  end

  frame_tick_counter #(
    .W (CW)
  ) u_frame_cnt (
    .i_clk_pix (i_clk_pix),
    .i_rst     (i_rst),
    .clear     (cnt_clear),
    .i_frame   (i_frame),
    .terminal  (cnt_terminal),
    .count     (cnt_value),
    .expire    (cnt_expire)
  );

  always_ff @(posedge i_clk_pix or posedge i_rst) begin
    if (i_rst) begin
      state_reg        <= ST_MENU;
      menu_active_reg  <= 1'b1;
      main_active_reg  <= 1'b0;
      main_start_reg   <= 1'b0;
      timeout_reg      <= 1'b0;
      done_pending_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        ST_MENU: begin
          if (i_start_req) begin
            state_reg      <= ST_WAIT;
            main_start_reg <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Ready takes priority over a timeout landing on the same edge.
          if (i_main_ready) begin
            state_reg      <= ST_FADE;
            main_start_reg <= 1'b0;
          end else if (cnt_expire) begin
            state_reg      <= ST_MENU;
            main_start_reg <= 1'b0;
            timeout_reg    <= 1'b1;
          end
        end
        ST_FADE: begin
          if (cnt_expire) begin
            state_reg       <= ST_PLAY;
            menu_active_reg <= 1'b0;
            main_active_reg <= 1'b1;
          end
        end
        ST_PLAY: begin
          // A done pulse coinciding with the frame pulse ends play at once;
          // otherwise it is remembered until the next frame boundary.
          if (i_frame && (i_main_done || done_pending_reg)) begin
            state_reg        <= ST_OVER;
            done_pending_reg <= 1'b0;
          end else if (i_main_done) begin
            done_pending_reg <= 1'b1;
          end
        end
        ST_OVER: begin
          if (cnt_expire) begin
            state_reg       <= ST_MENU;
            main_active_reg <= 1'b0;
            menu_active_reg <= 1'b1;
          end
        end
        default: begin
          state_reg        <= ST_MENU;
          menu_active_reg  <= 1'b1;
          main_active_reg  <= 1'b0;
          main_start_reg   <= 1'b0;
          done_pending_reg <= 1'b0;
        end
      endcase
    end
  end

  assign o_stage       = state_reg;
  assign o_menu_active = menu_active_reg;
  assign o_main_active = main_active_reg;
  assign o_main_start  = main_start_reg;
  assign o_timeout     = timeout_reg;
  // Derived from registers only; the count is zero on FADE entry.
  assign o_fade_level  = (state_reg == ST_FADE) ? FW'(cnt_value) : '0;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
// Directed, table-driven bench for stage_sequencer with FADE_FRAMES=4,
// HOLD_FRAMES=3, READY_TIMEOUT=5 and frame pulses every 20 cycles.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;
  import stage_pkg::*;

  localparam int FADE = 4;
  localparam int HOLD = 3;
  localparam int RTO  = 5;
  localparam int FW   = $clog2(FADE + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame = 1'b0;
  logic          start_req = 1'b0;
  logic          main_ready = 1'b0;
  logic          main_done = 1'b0;
  logic          main_start;
  logic          menu_active;
  logic          main_active;
  logic [2:0]    stage;
  logic [FW-1:0] fade_level;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_sequencer #(
    .FADE_FRAMES   (FADE),
    .HOLD_FRAMES   (HOLD),
    .READY_TIMEOUT (RTO)
  ) dut (
    .i_clk_pix     (clk),
    .i_rst         (rst),
    .i_frame       (frame),
    .i_start_req   (start_req),
    .i_main_ready  (main_ready),
    .i_main_done   (main_done),
    .o_main_start  (main_start),
    .o_menu_active (menu_active),
    .o_main_active (main_active),
    .o_stage       (stage),
    .o_fade_level  (fade_level),
    .o_timeout     (timeout)
  );

  typedef struct {
    bit         frm;     // wait 19 idle cycles, then apply with i_frame=1
    bit         start;
    bit         ready;
    bit         done;
    logic [2:0] stage;
    bit         menu;
    bit         main;
    bit         mstart;
    logic [2:0] fade;
    bit         tout;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit frm, bit st, bit rd, bit dn, logic [2:0] stg,
                              bit mn, bit ma, bit ms, logic [2:0] fd, bit to);
    vec_t v;
    v.frm = frm; v.start = st; v.ready = rd; v.done = dn;
    v.stage = stg; v.menu = mn; v.main = ma; v.mstart = ms; v.fade = fd; v.tout = to;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] stg, input bit mn, input bit ma,
                            input bit ms, input logic [2:0] fd, input bit to);
    check({tag, " stage"},       32'(stage),       32'(stg));
    check({tag, " menu_active"}, 32'(menu_active), 32'(mn));
    check({tag, " main_active"}, 32'(main_active), 32'(ma));
    check({tag, " main_start"},  32'(main_start),  32'(ms));
    check({tag, " fade_level"},  32'(fade_level),  32'(fd));
    check({tag, " timeout"},     32'(timeout),     32'(to));
  endtask

  // One step: optional idle gap so frame pulses stay 20 cycles apart, then one
  // cycle with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic tick(input bit frm, input bit st, input bit rd, input bit dn);
    if (frm) repeat (19) begin
      @(posedge clk);
      #1;
    end
    start_req  = st;
    main_ready = rd;
    main_done  = dn;
    frame      = frm;
    @(posedge clk);
    #1;
    start_req  = 1'b0;
    main_ready = 1'b0;
    main_done  = 1'b0;
    frame      = 1'b0;
  endtask

  // Layer-flag invariants, checked on every falling edge while enabled.
  bit   mon_en = 1'b0;
  logic frame_at_edge = 1'b0;
  logic prev_menu = 1'b1;
  logic prev_main = 1'b0;

  always @(posedge clk) frame_at_edge <= frame;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (menu_active == main_active) begin
        errors++;
        $display("FAIL invariant one_layer: menu=%0b main=%0b, required exactly one high",
                 menu_active, main_active);
      end
      checks++;
      if (((menu_active != prev_menu) || (main_active != prev_main)) && !frame_at_edge) begin
        errors++;
        $display("FAIL invariant frame_sync: layer flags changed to menu=%0b main=%0b without i_frame, required no change",
                 menu_active, main_active);
      end
    end
    prev_menu <= menu_active;
    prev_main <= main_active;
  end

  initial begin
    // Happy path: start, ready 3 cycles later, fade 0..3, play
    vq.push_back(mk(0,1,0,0, ST_WAIT,1,0,1,0,0));
    vq.push_back(mk(0,0,0,0, ST_WAIT,1,0,1,0,0));
    vq.push_back(mk(0,0,0,0, ST_WAIT,1,0,1,0,0));
    vq.push_back(mk(0,0,1,0, ST_FADE,1,0,0,0,0));
    vq.push_back(mk(1,0,0,0, ST_FADE,1,0,0,1,0));
    vq.push_back(mk(1,0,0,0, ST_FADE,1,0,0,2,0));
    vq.push_back(mk(1,0,0,1, ST_FADE,1,0,0,3,0));   // done ignored in FADE
    vq.push_back(mk(1,0,0,0, ST_PLAY,0,1,0,0,0));
    vq.push_back(mk(0,1,0,0, ST_PLAY,0,1,0,0,0));   // start ignored in PLAY
    vq.push_back(mk(1,0,0,0, ST_PLAY,0,1,0,0,0));   // no stale done from FADE
    vq.push_back(mk(0,0,0,1, ST_PLAY,0,1,0,0,0));   // done pending
    vq.push_back(mk(1,0,0,0, ST_OVER,0,1,0,0,0));
    vq.push_back(mk(1,0,0,0, ST_OVER,0,1,0,0,0));
    vq.push_back(mk(1,0,0,0, ST_OVER,0,1,0,0,0));
    vq.push_back(mk(1,0,0,0, ST_MENU,1,0,0,0,0));
    // Timeout: 5th frame in WAIT without ready
    vq.push_back(mk(0,1,0,0, ST_WAIT,1,0,1,0,0));
    for (int i = 0; i < RTO - 1; i++) vq.push_back(mk(1,0,0,0, ST_WAIT,1,0,1,0,0));
    vq.push_back(mk(1,0,0,0, ST_MENU,1,0,0,0,1));
    vq.push_back(mk(0,0,0,0, ST_MENU,1,0,0,0,0));
    // Collision: ready on the 5th frame wins
    vq.push_back(mk(0,1,0,0, ST_WAIT,1,0,1,0,0));
    for (int i = 0; i < RTO - 1; i++) vq.push_back(mk(1,0,0,0, ST_WAIT,1,0,1,0,0));
    vq.push_back(mk(1,0,1,0, ST_FADE,1,0,0,0,0));
    vq.push_back(mk(0,0,0,0, ST_FADE,1,0,0,0,0));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset_hold", ST_MENU, 1, 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outs("reset_release", ST_MENU, 1, 0, 0, 0, 0);
    @(negedge clk);
    mon_en = 1'b1;

    foreach (vq[i]) begin
      tick(vq[i].frm, vq[i].start, vq[i].ready, vq[i].done);
      $display("vec %0d: frm=%0b st=%0b rd=%0b dn=%0b -> stage=%0d menu=%0b main=%0b start=%0b fade=%0d tout=%0b",
               i, vq[i].frm, vq[i].start, vq[i].ready, vq[i].done,
               stage, menu_active, main_active, main_start, fade_level, timeout);
      check_outs($sformatf("vec%0d", i), vq[i].stage, vq[i].menu, vq[i].main,
                 vq[i].mstart, vq[i].fade, vq[i].tout);
    end

    // Game over with done coincident with the frame pulse (continuing in FADE)
    for (int i = 0; i < FADE; i++) tick(1, 0, 0, 0);
    check_outs("go_play", ST_PLAY, 0, 1, 0, 0, 0);
    tick(1, 0, 0, 1);
    check_outs("go_coincident", ST_OVER, 0, 1, 0, 0, 0);
    for (int i = 0; i < HOLD - 1; i++) tick(1, 0, 0, 0);
    check_outs("go_hold", ST_OVER, 0, 1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check_outs("go_menu", ST_MENU, 1, 0, 0, 0, 0);
    $display("seq game_over: stage=%0d menu=%0b main=%0b", stage, menu_active, main_active);

    // Asynchronous reset in the middle of PLAY
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    for (int i = 0; i < FADE; i++) tick(1, 0, 0, 0);
    check_outs("rst_pre", ST_PLAY, 0, 1, 0, 0, 0);
    mon_en = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_outs("rst_async", ST_MENU, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(0, 0, 0, 0);
    check_outs("rst_after", ST_MENU, 1, 0, 0, 0, 0);
    $display("seq reset: stage=%0d menu=%0b main=%0b", stage, menu_active, main_active);
    @(negedge clk);
    mon_en = 1'b1;
    tick(0, 1, 0, 0);
    check_outs("rst_restart", ST_WAIT, 1, 0, 1, 0, 0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
